// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master.
//   resp_t       : AXI response codes (BRESP/RRESP encoding)
//   mst_state_t  : master FSM state encoding
//   AXI_PROT_DEFAULT : protection attribute driven on awprot/arprot
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_AW_W = 3'd1,
      ST_WR_B    = 3'd2,
      ST_RD_AR   = 3'd3,
      ST_RD_R    = 3'd4
   } mst_state_t;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle.
// Ports : clk, rst_n (shared with the attached master/slave)
// Signals: AW (awvalid/awready/awaddr/awprot), W (wvalid/wready/wdata/wstrb),
//          B (bvalid/bready/bresp), AR (arvalid/arready/araddr/arprot),
//          R (rvalid/rready/rdata/rresp)
// Modports: master (initiator side), slave (responder side)
interface axi4_lite #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic clk,
   input logic rst_n
);

   logic                    awvalid;
   logic                    awready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;

   logic                    wvalid;
   logic                    wready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;

   logic                    bvalid;
   logic                    bready;
   logic [1:0]              bresp;

   logic                    arvalid;
   logic                    arready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;

   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;

   modport master (
      output awvalid, awaddr, awprot, input awready,
      output wvalid, wdata, wstrb, input wready,
      input bvalid, bresp, output bready,
      output arvalid, araddr, arprot, input arready,
      input rvalid, rdata, rresp, output rready
   );

   modport slave (
      input clk, rst_n,
      input awvalid, awaddr, awprot, output awready,
      input wvalid, wdata, wstrb, output wready,
      output bvalid, bresp, input bready,
      input arvalid, araddr, arprot, output arready,
      output rvalid, rdata, rresp, input rready
   );

endinterface

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns a valid/ready command port into single AXI4-Lite
// write (AW/W/B) or read (AR/R) transactions, one outstanding at a time, and
// reports each completion as a one-cycle pulse on the rsp_* port.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   axi4_m                AXI4-Lite master modport
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write, 0 = read
//   cmd_addr/wdata/wstrb  command payload (wdata/wstrb ignored for reads)
//   rsp_valid             one-cycle completion pulse
//   rsp_write/rdata/resp  completion info (rdata = 0 for writes)
//
// Build option
//   AXI4L_MST_TIMEOUT_EN  per-state watchdog; abandons a stalled transaction
//                         after TIMEOUT_CYCLES and reports DECERR.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_AW_W | awvalid/wvalid asserted, each drops on its own handshake
// WR_B    | bready high, waiting for the write response
// RD_AR   | arvalid asserted, waiting for arready
// RD_R    | rready high, waiting for read data
module axi4_lite_master
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   axi4_lite.master                axi4_m,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp
);

   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] WR_AW_W = ST_WR_AW_W;
   localparam logic [2:0] WR_B    = ST_WR_B;
   localparam logic [2:0] RD_AR   = ST_RD_AR;
   localparam logic [2:0] RD_R    = ST_RD_R;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("axi4_lite_master: TIMEOUT_CYCLES must be >= 2");
   end

   logic [2:0]              state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic                    aw_done;
   logic                    w_done;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    advance;
   logic                    timeout_hit;

   // Handshake-side outputs are decoded from state so they drop in the same
   // edge that moves the FSM (including reset and timeout).
   assign axi4_m.awvalid = (state == WR_AW_W) && !aw_done;
   assign axi4_m.wvalid  = (state == WR_AW_W) && !w_done;
   assign axi4_m.bready  = (state == WR_B);
   assign axi4_m.arvalid = (state == RD_AR);
   assign axi4_m.rready  = (state == RD_R);
   assign axi4_m.awaddr  = addr_q;
   assign axi4_m.araddr  = addr_q;
   assign axi4_m.wdata   = wdata_q;
   assign axi4_m.wstrb   = wstrb_q;
   assign axi4_m.awprot  = AXI_PROT_DEFAULT;
   assign axi4_m.arprot  = AXI_PROT_DEFAULT;

   // rst_n gates cmd_ready so nothing is offered while reset is held.
   assign cmd_ready = (state == IDLE) && rst_n;

   assign aw_hs = axi4_m.awvalid && axi4_m.awready;
   assign w_hs  = axi4_m.wvalid && axi4_m.wready;

   // advance: the handshake this state is waiting for completes this cycle.
   always_comb begin
      advance = 1'b0;
      case (state)
         WR_AW_W: advance = (aw_done || aw_hs) && (w_done || w_hs);
         WR_B:    advance = axi4_m.bvalid;
         RD_AR:   advance = axi4_m.arready;
         RD_R:    advance = axi4_m.rvalid;
         default: advance = 1'b0;
      endcase
   end

`ifdef AXI4L_MST_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] to_cnt;

   // Counter is 0 in the first cycle of every state, so the abort edge falls
   // TIMEOUT_CYCLES cycles after state entry.
   assign timeout_hit = (state != IDLE) && !advance && (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if ((state == IDLE) || advance || timeout_hit) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  state   <= cmd_write ? WR_AW_W : RD_AR;
               end
            end
            WR_AW_W: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
               if (advance) state <= WR_B;
            end
            WR_B: begin
               if (advance) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_write <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_resp  <= axi4_m.bresp;
               end
            end
            RD_AR: begin
               if (advance) state <= RD_R;
            end
            RD_R: begin
               if (advance) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_write <= 1'b0;
                  rsp_rdata <= axi4_m.rdata;
                  rsp_resp  <= axi4_m.rresp;
               end
            end
            default: state <= IDLE;
         endcase

         if (timeout_hit) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_write <= (state == WR_AW_W) || (state == WR_B);
            rsp_rdata <= '0;
            rsp_resp  <= DECERR;
         end
      end
   end

endmodule

// File: tb/tb_axi4_lite_master.sv
module tb_axi4_lite_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus (.clk(clk), .rst_n(rst_n));

   axi4_lite_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .axi4_m(bus),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic [31:0] mem [16];
   logic        s_awready, s_wready, s_arready, b_hold, rd_ovr;
   logic [31:0] ovr_data;
   logic [1:0]  ovr_resp;
   logic        got_aw, got_w;
   logic [31:0] aw_a, w_d;
   logic [3:0]  w_s;
   logic        aw_now, w_now;
   logic [31:0] aw_a_now, w_d_now;
   logic [3:0]  w_s_now;

   assign bus.awready = s_awready;
   assign bus.wready  = s_wready;
   assign bus.arready = s_arready;

   assign aw_now   = got_aw || (bus.awvalid && bus.awready);
   assign w_now    = got_w  || (bus.wvalid && bus.wready);
   assign aw_a_now = got_aw ? aw_a : bus.awaddr;
   assign w_d_now  = got_w  ? w_d  : bus.wdata;
   assign w_s_now  = got_w  ? w_s  : bus.wstrb;

   always @(posedge clk) begin
      if (!rst_n) begin
         bus.bvalid <= 1'b0;
         bus.bresp  <= 2'b00;
         bus.rvalid <= 1'b0;
         bus.rresp  <= 2'b00;
         bus.rdata  <= '0;
         got_aw     <= 1'b0;
         got_w      <= 1'b0;
      end else begin
         if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
         if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
         if (bus.awvalid && bus.awready) begin
            got_aw <= 1'b1;
            aw_a   <= bus.awaddr;
         end
         if (bus.wvalid && bus.wready) begin
            got_w <= 1'b1;
            w_d   <= bus.wdata;
            w_s   <= bus.wstrb;
         end
         if (!b_hold && aw_now && w_now && !bus.bvalid) begin
            for (int i = 0; i < 4; i++)
               if (w_s_now[i]) mem[aw_a_now[3:0]][8*i +: 8] <= w_d_now[8*i +: 8];
            bus.bvalid <= 1'b1;
            bus.bresp  <= 2'b00;
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
         end
         if (bus.arvalid && bus.arready && !bus.rvalid) begin
            bus.rvalid <= 1'b1;
            bus.rdata  <= rd_ovr ? ovr_data : mem[bus.araddr[3:0]];
            bus.rresp  <= rd_ovr ? ovr_resp : 2'b00;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        write;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          acc_cyc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   logic prev_rv = 1'b0;

   always @(negedge clk) begin
      if (rst_n && prev_rv) check("rsp_pulse_width", {31'b0, rsp_valid}, 32'd0);
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_write", {31'b0, rsp_write}, {31'b0, e.write});
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
            check("cmd_ready_with_rsp", {31'b0, cmd_ready}, 32'd1);
            if (e.lat > 0) check("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
         end
      end
      prev_rv = rst_n && rsp_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp,
                       input int lat, input logic keep, input logic push);
      int n;
      exp_t e;
      @(negedge clk);
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         n_vec++;
         n_miss++;
         $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 200 cycles");
      end else if (push) begin
         e.write   = wr;
         e.rdata   = er;
         e.resp    = eresp;
         e.acc_cyc = cyc;
         e.lat     = lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          lat;
      logic        keep;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      int cnt;

      vecs[0] = '{1'b1, 32'h1, 32'hAAAA_AAAA, 4'hF, 32'h0,         2'b00, 3, 1'b0};
      vecs[1] = '{1'b0, 32'h1, 32'h0,         4'h0, 32'hAAAA_AAAA, 2'b00, 3, 1'b0};
      vecs[2] = '{1'b1, 32'h1, 32'hAAAA_AAAA, 4'hF, 32'h0,         2'b00, 3, 1'b1};
      vecs[3] = '{1'b1, 32'h2, 32'h5555_5555, 4'hF, 32'h0,         2'b00, 3, 1'b1};
      vecs[4] = '{1'b1, 32'h3, 32'hF0F0_F0F0, 4'hF, 32'h0,         2'b00, 3, 1'b0};
      vecs[5] = '{1'b0, 32'h1, 32'h0,         4'h0, 32'hAAAA_AAAA, 2'b00, 3, 1'b1};
      vecs[6] = '{1'b0, 32'h2, 32'h0,         4'h0, 32'h5555_5555, 2'b00, 3, 1'b1};
      vecs[7] = '{1'b0, 32'h3, 32'h0,         4'h0, 32'hF0F0_F0F0, 2'b00, 3, 1'b0};

      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      s_awready = 1'b1;
      s_wready  = 1'b1;
      s_arready = 1'b1;
      b_hold    = 1'b0;
      rd_ovr    = 1'b0;
      ovr_data  = 32'h0;
      ovr_resp  = 2'b00;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      cmd_wstrb = 4'h0;
      rst_n     = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_awvalid", {31'b0, bus.awvalid}, 32'd0);
      check("rst_wvalid", {31'b0, bus.wvalid}, 32'd0);
      check("rst_arvalid", {31'b0, bus.arvalid}, 32'd0);
      check("rst_bready", {31'b0, bus.bready}, 32'd0);
      check("rst_rready", {31'b0, bus.rready}, 32'd0);
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_resp", {30'b0, rsp_resp}, 32'd0);
      check("rst_awaddr", bus.awaddr, 32'd0);
      check("rst_awprot", {29'b0, bus.awprot}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

      // single and back-to-back transactions
      for (int i = 0; i < 8; i++)
         send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
              vecs[i].exp_rdata, vecs[i].exp_resp, vecs[i].lat, vecs[i].keep, 1'b1);
      drain();

      // W channel stalled after AW handshake, partial strobes
      s_wready = 1'b0;
      fork
         send(1'b1, 32'h4, 32'h1234_5678, 4'h3, 32'h0, 2'b00, 0, 1'b0, 1'b1);
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(bus.awvalid && bus.awready) && n < 50);
            check("stall_aw_seen", {31'b0, bus.awvalid}, 32'd1);
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("stall_awvalid_low", {31'b0, bus.awvalid}, 32'd0);
               check("stall_wvalid_high", {31'b0, bus.wvalid}, 32'd1);
               check("stall_wdata", bus.wdata, 32'h1234_5678);
               check("stall_bready_low", {31'b0, bus.bready}, 32'd0);
            end
            s_wready = 1'b1;
         end
      join
      drain();
      send(1'b0, 32'h4, 32'h0, 4'h0, 32'h0000_5678, 2'b00, 3, 1'b0, 1'b1);
      drain();

      // error read response
      rd_ovr   = 1'b1;
      ovr_data = 32'hDEAD_BEEF;
      ovr_resp = 2'b10;
      send(1'b0, 32'h7, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b10, 3, 1'b0, 1'b1);
      drain();
      rd_ovr = 1'b0;

      // reset while waiting in WR_B
      b_hold = 1'b1;
      send(1'b1, 32'h5, 32'h0BAD_0BAD, 4'hF, 32'h0, 2'b00, 0, 1'b0, 1'b0);
      n = 0;
      while (!bus.bready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wr_b_reached", {31'b0, bus.bready}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_bready", {31'b0, bus.bready}, 32'd0);
      check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      rst_n  = 1'b1;
      b_hold = 1'b0;
      @(negedge clk);
      check("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      repeat (3) @(negedge clk);
      send(1'b0, 32'h5, 32'h0, 4'h0, 32'h0, 2'b00, 3, 1'b0, 1'b1);
      drain();

`ifdef AXI4L_MST_TIMEOUT_EN
      // watchdog on a dead AR channel
      s_arready = 1'b0;
      fork
         send(1'b0, 32'h1, 32'h0, 4'h0, 32'h0, 2'b11, 9, 1'b0, 1'b1);
         begin
            n = 0;
            while (!bus.arvalid && n < 50) begin
               @(negedge clk);
               n++;
            end
            cnt = 0;
            while (bus.arvalid && cnt < 50) begin
               @(negedge clk);
               cnt++;
            end
            check("timeout_arvalid_cycles", 32'(cnt), 32'd8);
         end
      join
      drain();
      s_arready = 1'b1;
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "bench time limit exceeded");
   end

endmodule
